// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared SHA-256 types, constants and bit-mixing functions.
//   word_t / block_t       : 32-bit word and 512-bit padded block
//   SHA256_ROUNDS          : schedule length / compression rounds
//   sched_state_t          : message-schedule FSM states
//   sigma0 / sigma1        : small-sigma functions used by the schedule
//   big_sigma0 / big_sigma1: big-Sigma functions used by the compression engine
// -----------------------------------------------------------------------------
package sha256_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [511:0] block_t;

  localparam int SHA256_ROUNDS = 64;
  localparam int SCHED_DEPTH   = 16;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_RUN  = 1'b1
  } sched_state_t;

  // Rotations are written as fixed concatenations so every shift is a constant
  // rewiring with no barrel shifter.

  // ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sigma0(input word_t x);
    word_t r7;
    word_t r18;
    word_t s3;
    r7  = {x[6:0],  x[31:7]};
    r18 = {x[17:0], x[31:18]};
    s3  = {3'b000,  x[31:3]};
    return r7 ^ r18 ^ s3;
  endfunction

  // ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sigma1(input word_t x);
    word_t r17;
    word_t r19;
    word_t s10;
    r17 = {x[16:0], x[31:17]};
    r19 = {x[18:0], x[31:19]};
    s10 = {10'd0,   x[31:10]};
    return r17 ^ r19 ^ s10;
  endfunction

  // ROTR2 ^ ROTR13 ^ ROTR22
  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  // ROTR6 ^ ROTR11 ^ ROTR25
  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// -----------------------------------------------------------------------------
// sha256_sched_word
// Combinational expansion of one schedule word:
//   W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16]  (mod 2^32)
// Ports:
//   w_m2, w_m7, w_m15, w_m16 : in  32  buffer taps W[t-2], W[t-7], W[t-15], W[t-16]
//   w_new                    : out 32  expanded word W[t]
// -----------------------------------------------------------------------------
module sha256_sched_word
  import sha256_pkg::*;
(
  input  word_t w_m2,
  input  word_t w_m7,
  input  word_t w_m15,
  input  word_t w_m16,
  output word_t w_new
);

  // Carries out of bit 31 are dropped, giving the required mod 2^32 sum.
  assign w_new = sigma1(w_m2) + w_m7 + sigma0(w_m15) + w_m16;

endmodule

// File: rtl/sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule
// Expands each 512-bit padded block into the SHA-256 message schedule
// W[0..ROUNDS-1] and streams the words out one per handshake.
// Ports:
//   clk        in   1    clock, all state on rising edge
//   rst_n      in   1    asynchronous active-low reset
//   blk_valid  in   1    upstream presents a padded block on blk_data
//   blk_ready  out  1    schedule can accept a block (IDLE)
//   blk_data   in   512  block; word 0 = [511:480], word 15 = [31:0]
//   w_valid    out  1    w_word / w_index valid (RUN)
//   w_ready    in   1    downstream accepts the current word
//   w_word     out  32   schedule word W[w_index]
//   w_index    out  6    round index t, 0..ROUNDS-1
//   w_last     out  1    current word is W[ROUNDS-1]
//   busy       out  1    FSM is in RUN; doubles as the state debug view
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until that edge;
// ready may change freely and never depends combinationally on valid from the
// same side. blk_ready depends only on state; w_valid depends only on state.
//
// Word storage is a 16-entry circular buffer indexed by t[3:0]. Slot t&15
// holds W[t-16] when t>=16, which is exactly the oldest tap, so the newly
// computed W[t] overwrites it on the handshake.
// -----------------------------------------------------------------------------
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_word,
  output logic [5:0]   w_index,
  output logic         w_last,
  output logic         busy
);

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  sched_state_t state_q;
  sched_state_t state_d;
  logic [5:0]   t_q;
  word_t        buf_q [SCHED_DEPTH];

  logic         accept;
  logic         fire;
  logic         at_last;
  logic         expanding;
  logic [3:0]   slot;
  word_t        new_word;

  // ---------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    blk_ready = 1'b0;
    w_valid   = 1'b0;
    busy      = 1'b0;
    case (state_q)
      SCHED_IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) state_d = SCHED_RUN;
      end
      SCHED_RUN: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        // No same-cycle re-acceptance: blk_ready only rises once back in IDLE.
        if (w_ready && (t_q == LAST_T)) state_d = SCHED_IDLE;
      end
      default: begin
        state_d = SCHED_IDLE;
      end
    endcase
  end

  assign accept    = blk_valid & blk_ready;
  assign fire      = w_valid & w_ready;
  assign at_last   = busy && (t_q == LAST_T);
  assign expanding = (t_q[5:4] != 2'b00);   // t >= 16
  assign slot      = t_q[3:0];

  // ---------------------------------------------------------------------------
  // Expansion datapath; 4-bit subtraction wraps mod 16 to address the
  // circular buffer taps.
  // ---------------------------------------------------------------------------
  sha256_sched_word u_sched_word (
    .w_m2  (buf_q[slot - 4'd2]),
    .w_m7  (buf_q[slot - 4'd7]),
    .w_m15 (buf_q[slot - 4'd15]),
    .w_m16 (buf_q[slot]),
    .w_new (new_word)
  );

  always_comb begin
    w_word  = '0;
    w_index = '0;
    w_last  = 1'b0;
    if (busy) begin
      w_word  = expanding ? new_word : buf_q[slot];
      w_index = t_q;
      w_last  = at_last;
    end
  end

  // ---------------------------------------------------------------------------
  // State and round counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCHED_IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        t_q <= '0;
      end else if (fire) begin
        t_q <= at_last ? 6'd0 : t_q + 6'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Circular word buffer. Stale W[48..63] are left in place between blocks;
  // the next acceptance overwrites all 16 slots.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SCHED_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < SCHED_DEPTH; i++) begin
        buf_q[i] <= blk_data[511 - 32*i -: 32];
      end
    end else if (fire && expanding) begin
      buf_q[slot] <= new_word;
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_schedule
// Directed bench for sha256_msg_schedule: the padded "abc" block, random
// backpressure, blk_valid held during RUN, a two-block message, and an
// asynchronous reset in the middle of a schedule.
// -----------------------------------------------------------------------------
module tb_sha256_msg_schedule;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_word;
  logic [5:0]   w_index;
  logic         w_last;
  logic         busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_word    (w_word),
    .w_index   (w_index),
    .w_last    (w_last),
    .busy      (busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got [64];
  int          accept_cyc;
  int          last_fire_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model, written from the SHA-256 definitions.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic load_model(input logic [511:0] b);
    logic [31:0] w [64];
    exp_q.delete();
    for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) exp_q.push_back(w[t]);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic accept_block(input logic [511:0] b);
    int guard;
    guard     = 0;
    blk_data  = b;
    blk_valid = 1'b1;
    while (!blk_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", blk_ready, 1);
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc;
    blk_valid  = 1'b0;
  endtask

  // Streams words until stop_at of them have fired, checking every cycle
  // (stalled cycles included) against the front of the expected queue.
  task automatic drain(input logic [511:0] b, input bit rand_ready,
                       input bit present_next, input logic [511:0] next_b,
                       input int stop_at);
    int idx;
    int guard;
    bit fired;
    load_model(b);
    check("first_valid", w_valid, 1);
    if (present_next) begin
      blk_valid = 1'b1;
      blk_data  = next_b;
    end
    idx   = 0;
    guard = 0;
    while (idx < stop_at && guard < 2000) begin
      w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      check("w_valid", w_valid, 1);
      check("w_index", w_index, idx);
      check("w_word", w_word, exp_q[0]);
      check("w_last", w_last, (idx == 63));
      check("blk_ready_run", blk_ready, 0);
      check("busy_run", busy, 1);
      fired = w_ready;
      if (fired) got[idx] = w_word;
      @(posedge clk);
      @(negedge clk);
      if (fired) begin
        void'(exp_q.pop_front());
        idx++;
        last_fire_cyc = cyc;
      end
      guard++;
    end
    w_ready = 1'b1;
    check("drain_count", idx, stop_at);
    if (stop_at == 64) begin
      check("blk_ready_after_last", blk_ready, 1);
      check("w_valid_after_last", w_valid, 0);
      check("busy_after_last", busy, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blk_ready"}, blk_ready, 1);
    check({tag, "_w_valid"}, w_valid, 0);
    check({tag, "_w_index"}, w_index, 0);
    check({tag, "_w_last"}, w_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_w_word"}, w_word, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [511:0] abc_blk;
  logic [511:0] other_blk;
  logic [511:0] b1_blk;
  logic [511:0] b2_blk;
  logic [31:0]  other_w0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    for (int i = 0; i < 16; i++) other_blk[511 - 32*i -: 32] = 32'hA5C3_0000 + 32'(i * 32'h1111);
    other_w0 = other_blk[511:480];
    b1_blk = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    b2_blk = {480'h0, 32'h000001c0};

    blk_valid = 1'b0;
    blk_data  = '0;
    w_ready   = 1'b1;

    // Reset state
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: "abc" block, w_ready always high
    accept_block(abc_blk);
    drain(abc_blk, 1'b0, 1'b0, '0, 64);
    check("abc_w0", got[0], 32'h61626380);
    check("abc_w15", got[15], 32'h00000018);
    check("abc_w16", got[16], 32'h61626380);
    check("abc_w17", got[17], 32'h000F0000);
    check("abc_w18", got[18], 32'h7DA86405);
    check("abc_w19", got[19], 32'h600003C6);
    check("abc_w63", got[63], 32'h12B1EDEB);

    // 2: same block with random backpressure
    accept_block(abc_blk);
    drain(abc_blk, 1'b1, 1'b0, '0, 64);
    check("bp_w18", got[18], 32'h7DA86405);
    check("bp_w63", got[63], 32'h12B1EDEB);

    // 3: second block waiting on blk_valid throughout RUN
    accept_block(abc_blk);
    drain(abc_blk, 1'b0, 1'b1, other_blk, 64);
    check("held_blk_valid", blk_valid, 1);
    accept_block(other_blk);
    check("held_accept_gap", accept_cyc - last_fire_cyc, 1);
    drain(other_blk, 1'b0, 1'b0, '0, 64);
    check("held_w0", got[0], other_w0);

    // 4: two back-to-back blocks of the 448-bit message
    accept_block(b1_blk);
    begin
      int t0;
      t0 = accept_cyc;
      drain(b1_blk, 1'b0, 1'b1, b2_blk, 64);
      accept_block(b2_blk);
      drain(b2_blk, 1'b0, 1'b0, '0, 64);
      check("two_block_span", last_fire_cyc - t0 + 1, 130);
    end
    check("b2_w0", got[0], 32'h0);
    check("b2_w15", got[15], 32'h000001c0);
    check("b2_w16", got[16], 32'h0);
    check("b2_w17", got[17], 32'h00D80000);

    // 5: asynchronous reset at w_index 30
    accept_block(abc_blk);
    drain(abc_blk, 1'b0, 1'b0, '0, 30);
    check("pre_reset_index", w_index, 30);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    accept_block(abc_blk);
    drain(abc_blk, 1'b0, 1'b0, '0, 64);
    check("post_reset_w16", got[16], 32'h61626380);
    check("post_reset_w63", got[63], 32'h12B1EDEB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
